// File: rtl/filter_load_pkg.sv
// Shared types and width helpers for the filter coefficient load controller.
package filter_load_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } load_state_e;

  // Bank-select width never drops below one bit, even for a single bank.
  function automatic int lg_banks(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter must represent 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/filter_bank_tracker.sv
// Ring of filter banks: write pointer, oldest-full read pointer and occupancy count.
module filter_bank_tracker
  import filter_load_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int LG_BANKS  = lg_banks(NUM_BANKS),
  parameter int CNT_W     = cnt_width(NUM_BANKS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fill_i,
  input  logic                release_i,
  output logic [LG_BANKS-1:0] wr_bank_o,
  output logic [LG_BANKS-1:0] rd_bank_o,
  output logic                filter_avail_o,
  output logic                bank_free_o
);

  localparam logic [LG_BANKS-1:0] LAST_BANK = LG_BANKS'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(NUM_BANKS);

  logic [LG_BANKS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LG_BANKS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rel_ok;

  // A release with nothing held is dropped; fill and release together leave the count alone.
  always_comb begin
    rel_ok   = release_i && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fill_i) begin
      wr_ptr_d = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rel_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + 1'b1;
    end
    if (fill_i && !rel_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!fill_i && rel_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_bank_o      = wr_ptr_q;
  assign rd_bank_o      = rd_ptr_q;
  assign filter_avail_o = (cnt_q != '0);
  assign bank_free_o    = (cnt_q < MAX_CNT);

endmodule

// File: rtl/filter_load_ctrl.sv
// F-vector load controller: streams FILTER_N taps per filter into a multi-bank filter memory.
// Optional FILTER_LOAD_ABORT_EN enables load_abort to discard a partial filter.
module filter_load_ctrl
  import filter_load_pkg::*;
#(
  parameter int FILTER_N    = 8,
  parameter int NUM_BANKS   = 2,
  parameter int LG_FILTER_N = $clog2(FILTER_N),
  parameter int LG_BANKS    = lg_banks(NUM_BANKS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_req,
  input  logic                   s_valid_f,
  output logic                   s_ready_f,
  output logic [LG_FILTER_N-1:0] addr_f,
  output logic [LG_BANKS-1:0]    bank_f,
  output logic                   wr_en_f,
  output logic                   done_f,
  output logic                   load_busy,
  output logic                   filter_avail,
  output logic [LG_BANKS-1:0]    rd_bank,
  input  logic                   bank_release,
  input  logic                   load_abort
);

  localparam logic [LG_FILTER_N-1:0] LAST_TAP = LG_FILTER_N'(FILTER_N - 1);

  load_state_e            state_q, state_d;
  logic [LG_FILTER_N-1:0] addr_q, addr_d;
  logic                   done_q, done_d;
  logic                   beat, last_beat, abort, fill, bank_free;

`ifdef FILTER_LOAD_ABORT_EN
  assign abort = load_abort && (state_q == ST_LOAD);
`else
  logic unused_abort;
  assign unused_abort = load_abort;
  assign abort        = 1'b0;
`endif

  assign s_ready_f = (state_q == ST_LOAD);
  assign beat      = s_valid_f && s_ready_f;
  assign wr_en_f   = beat;
  assign last_beat = beat && (addr_q == LAST_TAP);
  // An abort on the last beat still writes the word but the filter never counts as full.
  assign fill      = last_beat && !abort;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = fill;
    case (state_q)
      ST_IDLE: begin
        if (load_req && bank_free) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort || last_beat) begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end else if (beat) begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign addr_f    = addr_q;
  assign done_f    = done_q;
  assign load_busy = (state_q == ST_LOAD);

  filter_bank_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .LG_BANKS  (LG_BANKS)
  ) u_tracker (
    .clk            (clk),
    .reset_n        (reset_n),
    .fill_i         (fill),
    .release_i      (bank_release),
    .wr_bank_o      (bank_f),
    .rd_bank_o      (rd_bank),
    .filter_avail_o (filter_avail),
    .bank_free_o    (bank_free)
  );

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Self-checking bench for filter_load_ctrl: 8-tap/2-bank main instance plus a 5-tap instance.
module tb_filter_load_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       loadReq, sValid, bankRelease, loadAbort;
  logic       sReady, wrEn, doneF, loadBusy, filterAvail;
  logic [2:0] addrF;
  logic [0:0] bankF, rdBank;

  logic       loadReq5, sValid5, bankRelease5, loadAbort5;
  logic       sReady5, wrEn5, done5, busy5, avail5;
  logic [2:0] addr5;
  logic [0:0] bank5, rd5;

  logic [3:0] expQ[$];
  logic [3:0] obsQ[$];
  logic [2:0] exp5Q[$];
  logic [2:0] obs5Q[$];
  int         doneCnt;
  int         nChecks = 0;
  int         nFails  = 0;

  always #5 clk = ~clk;

  filter_load_ctrl #(.FILTER_N(8), .NUM_BANKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .load_req(loadReq), .s_valid_f(sValid),
    .s_ready_f(sReady), .addr_f(addrF), .bank_f(bankF), .wr_en_f(wrEn),
    .done_f(doneF), .load_busy(loadBusy), .filter_avail(filterAvail),
    .rd_bank(rdBank), .bank_release(bankRelease), .load_abort(loadAbort)
  );

  filter_load_ctrl #(.FILTER_N(5), .NUM_BANKS(2)) dut5 (
    .clk(clk), .reset_n(reset_n), .load_req(loadReq5), .s_valid_f(sValid5),
    .s_ready_f(sReady5), .addr_f(addr5), .bank_f(bank5), .wr_en_f(wrEn5),
    .done_f(done5), .load_busy(busy5), .filter_avail(avail5),
    .rd_bank(rd5), .bank_release(bankRelease5), .load_abort(loadAbort5)
  );

  // Observed memory writes and done pulses are captured mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (wrEn)  obsQ.push_back({bankF, addrF});
    if (doneF) doneCnt++;
    if (wrEn5) obs5Q.push_back(addr5);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n consecutive valid beats and records the writes they should produce.
  task automatic feedBeats(input int n, input logic bank, input int firstAddr);
    sValid = 1'b1;
    for (int i = 0; i < n; i++) begin
      expQ.push_back({bank, 3'(firstAddr + i)});
      step();
    end
    sValid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nChecks++; if ({sReady, wrEn, addrF, bankF, doneF, loadBusy, filterAvail, rdBank} !== 10'b0) begin nFails++; $display("[TB] FAIL reset_outputs: got %b want 0", {sReady, wrEn, addrF, bankF, doneF, loadBusy, filterAvail, rdBank}); end
    nChecks++; if ({sReady5, wrEn5, addr5, bank5, done5, busy5, avail5, rd5} !== 10'b0) begin nFails++; $display("[TB] FAIL reset_outputs5: got %b want 0", {sReady5, wrEn5, addr5, bank5, done5, busy5, avail5, rd5}); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_load();
    logic [3:0] e, g;
    expQ.delete(); obsQ.delete(); doneCnt = 0;
    loadReq = 1'b1;
    step();
    loadReq = 1'b0;
    nChecks++; if (sReady !== 1'b1) begin nFails++; $display("[TB] FAIL single_ready: got %b want 1", sReady); end
    feedBeats(8, 1'b0, 0);
    nChecks++; if (doneF !== 1'b1) begin nFails++; $display("[TB] FAIL single_done: got %b want 1", doneF); end
    nChecks++; if (filterAvail !== 1'b1) begin nFails++; $display("[TB] FAIL single_avail: got %b want 1", filterAvail); end
    nChecks++; if (bankF !== 1'b1) begin nFails++; $display("[TB] FAIL single_bank: got %b want 1", bankF); end
    nChecks++; if (rdBank !== 1'b0) begin nFails++; $display("[TB] FAIL single_rdbank: got %b want 0", rdBank); end
    nChecks++; if ({addrF, loadBusy} !== 4'b0) begin nFails++; $display("[TB] FAIL single_idle: got %b want 0", {addrF, loadBusy}); end
    step();
    nChecks++; if (doneF !== 1'b0) begin nFails++; $display("[TB] FAIL single_done_width: got %b want 0", doneF); end
    step();
    nChecks++; if (doneCnt !== 1) begin nFails++; $display("[TB] FAIL single_done_count: got %0d want 1", doneCnt); end
    nChecks++; if (obsQ.size() !== expQ.size()) begin nFails++; $display("[TB] FAIL single_write_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      nChecks++; if (g !== e) begin nFails++; $display("[TB] FAIL single_write: got %h want %h", g, e); end
    end
  endtask

  task automatic test_gapped();
    exp5Q.delete(); obs5Q.delete();
    loadReq5 = 1'b1;
    step();
    loadReq5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sValid5 = (i % 2 == 0);
      if (i % 2 == 0 && i < 10) exp5Q.push_back(3'(i / 2));
      step();
    end
    sValid5 = 1'b0;
    nChecks++; if (obs5Q.size() !== 5) begin nFails++; $display("[TB] FAIL gapped_write_count: got %0d want 5", obs5Q.size()); end
    while (exp5Q.size() > 0 && obs5Q.size() > 0) begin
      logic [2:0] e5, g5;
      e5 = exp5Q.pop_front(); g5 = obs5Q.pop_front();
      nChecks++; if (g5 !== e5) begin nFails++; $display("[TB] FAIL gapped_write_addr: got %0d want %0d", g5, e5); end
    end
    nChecks++; if ({addr5, busy5, avail5, bank5} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin nFails++; $display("[TB] FAIL gapped_final: got %b want 00011", {addr5, busy5, avail5, bank5}); end
  endtask

  task automatic test_all_full_and_release();
    logic [3:0] e, g;
    expQ.delete(); obsQ.delete();
    loadReq = 1'b1;
    step();
    feedBeats(8, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      nChecks++; if ({sReady, loadBusy} !== 2'b00) begin nFails++; $display("[TB] FAIL full_stall: got %b want 00", {sReady, loadBusy}); end
    end
    bankRelease = 1'b1;
    step();
    bankRelease = 1'b0;
    nChecks++; if (rdBank !== 1'b1) begin nFails++; $display("[TB] FAIL release_rdbank: got %b want 1", rdBank); end
    step();
    nChecks++; if (sReady !== 1'b1) begin nFails++; $display("[TB] FAIL release_resume: got %b want 1", sReady); end
    feedBeats(7, 1'b0, 0);
    // Last beat coincides with a release while one bank is held.
    sValid = 1'b1; bankRelease = 1'b1;
    expQ.push_back({1'b0, 3'd7});
    step();
    sValid = 1'b0; bankRelease = 1'b0;
    nChecks++; if ({bankF, rdBank, filterAvail, doneF} !== 4'b1011) begin nFails++; $display("[TB] FAIL same_cycle_ptrs: got %b want 1011", {bankF, rdBank, filterAvail, doneF}); end
    nChecks++; if (sReady !== 1'b0) begin nFails++; $display("[TB] FAIL bubble: got %b want 0", sReady); end
    step();
    nChecks++; if (sReady !== 1'b1) begin nFails++; $display("[TB] FAIL same_cycle_count: got %b want 1", sReady); end
    nChecks++; if (obsQ.size() !== expQ.size()) begin nFails++; $display("[TB] FAIL full_write_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      nChecks++; if (g !== e) begin nFails++; $display("[TB] FAIL full_write: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] e, g;
    expQ.delete(); obsQ.delete();
    loadReq = 1'b0;
    feedBeats(3, 1'b1, 0);
    sValid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    nChecks++; if ({sReady, wrEn, addrF, bankF, doneF, loadBusy, filterAvail, rdBank} !== 10'b0) begin nFails++; $display("[TB] FAIL async_reset: got %b want 0", {sReady, wrEn, addrF, bankF, doneF, loadBusy, filterAvail, rdBank}); end
    sValid = 1'b0;
    reset_n = 1'b1;
    step();
    loadReq = 1'b1;
    step();
    loadReq = 1'b0;
    feedBeats(8, 1'b0, 0);
    nChecks++; if ({bankF, doneF, filterAvail} !== 3'b111) begin nFails++; $display("[TB] FAIL post_reset_load: got %b want 111", {bankF, doneF, filterAvail}); end
    step();
    nChecks++; if (obsQ.size() !== expQ.size()) begin nFails++; $display("[TB] FAIL reset_write_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      nChecks++; if (g !== e) begin nFails++; $display("[TB] FAIL reset_write: got %h want %h", g, e); end
    end
  endtask

`ifdef FILTER_LOAD_ABORT_EN
  task automatic test_abort();
    logic [3:0] e, g;
    int doneBefore;
    expQ.delete(); obsQ.delete();
    doneBefore = doneCnt;
    loadReq = 1'b1;
    step();
    feedBeats(4, 1'b1, 0);
    loadAbort = 1'b1;
    step();
    loadAbort = 1'b0;
    nChecks++; if ({addrF, loadBusy, bankF} !== 5'b00001) begin nFails++; $display("[TB] FAIL abort_state: got %b want 00001", {addrF, loadBusy, bankF}); end
    step();
    nChecks++; if (doneCnt !== doneBefore) begin nFails++; $display("[TB] FAIL abort_no_done: got %0d want %0d", doneCnt, doneBefore); end
    loadReq = 1'b0;
    feedBeats(8, 1'b1, 0);
    nChecks++; if ({bankF, doneF} !== 2'b01) begin nFails++; $display("[TB] FAIL abort_reload: got %b want 01", {bankF, doneF}); end
    step();
    nChecks++; if (obsQ.size() !== expQ.size()) begin nFails++; $display("[TB] FAIL abort_write_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      nChecks++; if (g !== e) begin nFails++; $display("[TB] FAIL abort_write: got %h want %h", g, e); end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    loadReq = 1'b0; sValid = 1'b0; bankRelease = 1'b0; loadAbort = 1'b0;
    loadReq5 = 1'b0; sValid5 = 1'b0; bankRelease5 = 1'b0; loadAbort5 = 1'b0;
    doneCnt = 0;
    test_reset();
    test_single_load();
    test_gapped();
    test_all_full_and_release();
    test_reset_mid_load();
`ifdef FILTER_LOAD_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
